// File: rtl/ram_bist.sv
// March-style RAM self-test: two write-all/read-all passes (pattern, then its inverse)
// with a one-stage compare pipeline, saturating error count and first-failure address.
module ram_bist #(
  parameter int ADSize  = 4,
  parameter int DASize  = 16,
  parameter int RAMSize = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DASize-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADSize-1:0] fail_addr,
  output logic [ADSize+1:0] err_cnt,
  output logic              en_read,
  output logic              en_write,
  output logic [ADSize-1:0] addr,
  output logic [DASize-1:0] DMin,
  input  logic [DASize-1:0] DMout
);

  // state | meaning
  // IDLE  | waiting for start, RAM ports quiet
  // WRITE | one pattern word written per cycle, addr 0..RAMSize-1
  // READ  | one read per cycle; compare happens a cycle later
  // DRAIN | compare of the final read word, then next phase or DONE
  // DONE  | one-cycle done pulse, pass published

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADSize-1:0] LAST    = ADSize'(RAMSize - 1);
  localparam logic [ADSize+1:0] ERR_MAX = '1;

  state_t            state, state_n;
  logic              phase, phase_n;
  logic [DASize-1:0] seed_q, seed_n;
  logic [ADSize-1:0] idx, idx_n;
  logic [ADSize-1:0] left, left_n;
  logic              busy_n, done_n, pass_n;
  logic [ADSize-1:0] fail_n;
  logic [ADSize+1:0] err_n;
  logic              rd_n, wr_n;
  logic [ADSize-1:0] addr_n;
  logic [DASize-1:0] din_n;
  logic              cmp_vld, cmp_vld_n;
  logic [ADSize-1:0] cmp_addr, cmp_addr_n;
  logic [DASize-1:0] cmp_exp, cmp_exp_n;
  logic              mism;

  function automatic logic [DASize-1:0] pattern(input logic [DASize-1:0] s,
                                                 input logic [ADSize-1:0] i,
                                                 input logic              ph);
    logic [DASize-1:0] b;
    b = s + DASize'(i);
    return ph ? ~b : b;
  endfunction

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    seed_n     = seed_q;
    idx_n      = idx;
    left_n     = left;
    busy_n     = busy;
    done_n     = 1'b0;
    pass_n     = pass;
    fail_n     = fail_addr;
    err_n      = err_cnt;
    rd_n       = 1'b0;
    wr_n       = 1'b0;
    addr_n     = '0;
    din_n      = '0;
    cmp_vld_n  = (state == S_READ);
    cmp_addr_n = idx;
    cmp_exp_n  = pattern(seed_q, idx, phase);

    // err_cnt never returns to zero within a test, so zero means "first mismatch"
    mism = cmp_vld && (DMout != cmp_exp);
    if (mism) begin
      if (err_cnt == '0) fail_n = cmp_addr;
      if (err_cnt != ERR_MAX) err_n = err_cnt + (ADSize+2)'(1);
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WRITE;
          seed_n  = seed;
          phase_n = 1'b0;
          err_n   = '0;
          fail_n  = '0;
          pass_n  = 1'b0;
          busy_n  = 1'b1;
          idx_n   = '0;
          left_n  = LAST;
          wr_n    = 1'b1;
          din_n   = pattern(seed, '0, 1'b0);
        end
      end

      S_WRITE: begin
        if (left == '0) begin
          state_n = S_READ;
          idx_n   = '0;
          left_n  = LAST;
          rd_n    = 1'b1;
        end else begin
          idx_n  = idx + ADSize'(1);
          left_n = left - ADSize'(1);
          wr_n   = 1'b1;
          addr_n = idx + ADSize'(1);
          din_n  = pattern(seed_q, idx + ADSize'(1), phase);
        end
      end

      S_READ: begin
        if (left == '0) begin
          state_n = S_DRAIN;
          idx_n   = '0;
        end else begin
          idx_n  = idx + ADSize'(1);
          left_n = left - ADSize'(1);
          rd_n   = 1'b1;
          addr_n = idx + ADSize'(1);
        end
      end

      S_DRAIN: begin
        if (!phase) begin
          state_n = S_WRITE;
          phase_n = 1'b1;
          idx_n   = '0;
          left_n  = LAST;
          wr_n    = 1'b1;
          din_n   = pattern(seed_q, '0, 1'b1);
        end else begin
          state_n = S_DONE;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= 1'b0;
      seed_q    <= '0;
      idx       <= '0;
      left      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      err_cnt   <= '0;
      en_read   <= 1'b0;
      en_write  <= 1'b0;
      addr      <= '0;
      DMin      <= '0;
      cmp_vld   <= 1'b0;
      cmp_addr  <= '0;
      cmp_exp   <= '0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      seed_q    <= seed_n;
      idx       <= idx_n;
      left      <= left_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      fail_addr <= fail_n;
      err_cnt   <= err_n;
      en_read   <= rd_n;
      en_write  <= wr_n;
      addr      <= addr_n;
      DMin      <= din_n;
      cmp_vld   <= cmp_vld_n;
      cmp_addr  <= cmp_addr_n;
      cmp_exp   <= cmp_exp_n;
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural RAM with injectable read faults, write-stream and
// result scoreboards filled at start time and drained as the DUT writes / signals done.
module tb_ram_bist;

  localparam int ADS      = 4;
  localparam int DAS      = 16;
  localparam int R        = 16;
  localparam int DONE_CYC = 4 * R + 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [DAS-1:0] seed;
  logic           busy, done, pass;
  logic [ADS-1:0] fail_addr;
  logic [ADS+1:0] err_cnt;
  logic           en_read, en_write;
  logic [ADS-1:0] addr;
  logic [DAS-1:0] DMin;
  logic [DAS-1:0] DMout;

  ram_bist #(.ADSize(ADS), .DASize(DAS), .RAMSize(R)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .err_cnt(err_cnt),
    .en_read(en_read), .en_write(en_write), .addr(addr), .DMin(DMin), .DMout(DMout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADS-1:0] a;
    logic [DAS-1:0] d;
  } wr_t;

  typedef struct {
    int             cyc;
    logic           p;
    logic [ADS+1:0] e;
    logic [ADS-1:0] f;
  } res_t;

  wr_t  wq[$];
  res_t rq[$];

  int checks = 0, failures = 0;
  int ecnt = 0, start_ecnt = 0;
  int fault_mode = 0;
  int done_cnt = 0;
  bit done_seen = 0, busy_chk = 0;
  int excl_err = 0, dmin_err = 0, addr_err = 0, busy_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // fault injection on the read path of the behavioural RAM
  function automatic logic [DAS-1:0] ram_rd(input int mode, input logic [ADS-1:0] a,
                                            input logic [DAS-1:0] stored);
    if (mode == 1 && a == 4'd5) return stored & 16'hFFFE;
    if (mode == 2 && (a == 4'd3 || a == 4'd9)) return 16'hAAAA;
    return stored;
  endfunction

  logic [DAS-1:0] mem[R];
  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (en_write) mem[addr] <= DMin;
    if (en_read)  DMout <= ram_rd(fault_mode, addr, mem[addr]);
  end

  function automatic void push_expect(input logic [DAS-1:0] s, input int mode, input bit with_res);
    logic [DAS-1:0] p;
    int err = 0;
    logic [ADS-1:0] fa = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < R; i++) begin
        p = s + 16'(i);
        if (ph == 1) p = ~p;
        wq.push_back('{a: 4'(i), d: p});
        if (ram_rd(mode, 4'(i), p) != p) begin
          if (err == 0) fa = 4'(i);
          if (err < 63) err++;
        end
      end
    end
    if (with_res) rq.push_back('{cyc: DONE_CYC, p: (err == 0), e: 6'(err), f: fa});
  endfunction

  wr_t  mw;
  res_t mr;
  int   mcyc;
  always @(negedge clk) begin
    mcyc = ecnt - start_ecnt + 1;
    if (en_read && en_write) excl_err++;
    if (!en_write && DMin != '0) dmin_err++;
    if (!en_write && !en_read && addr != '0) addr_err++;
    if (busy_chk && busy != (mcyc >= 1 && mcyc <= DONE_CYC)) busy_err++;
    if (en_write) begin
      if (wq.size() == 0) chk("write_unexpected", 32'(en_write), 32'd0);
      else begin
        mw = wq.pop_front();
        chk("write_addr", 32'(addr), 32'(mw.a));
        chk("write_data", 32'(DMin), 32'(mw.d));
      end
    end
    if (done) begin
      done_cnt++;
      done_seen = 1;
      if (rq.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
      else begin
        mr = rq.pop_front();
        chk("done_cycle", 32'(mcyc), 32'(mr.cyc));
        chk("pass", 32'(pass), 32'(mr.p));
        chk("err_cnt", 32'(err_cnt), 32'(mr.e));
        chk("fail_addr", 32'(fail_addr), 32'(mr.f));
      end
    end
  end

  task automatic run_test(input logic [DAS-1:0] s, input int mode, input bit glitch);
    int c;
    @(negedge clk);
    fault_mode = mode;
    seed       = s;
    start      = 1'b1;
    push_expect(s, mode, 1'b1);
    start_ecnt = ecnt + 1;
    done_seen  = 0;
    done_cnt   = 0;
    busy_chk   = 1;
    @(negedge clk);
    start = 1'b0;
    seed  = ~s;
    for (int n = 0; n < 200 && !done_seen; n++) begin
      @(negedge clk);
      c = ecnt - start_ecnt + 1;
      if (glitch) start = (c == 10 || c == 40);
      seed = 16'($urandom);
      #1;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_seen), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    seed  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_addr", 32'(fail_addr), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_req", 32'({en_read, en_write}), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_dmin", 32'(DMin), 32'd0);
    rst = 1'b0;

    run_test(16'h0001, 0, 1'b0);
    run_test(16'hFFF8, 0, 1'b0);
    run_test(16'h0000, 1, 1'b0);
    run_test(16'h0000, 2, 1'b0);
    run_test(16'h1234, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("pass_hold", 32'(pass), 32'd1);

    run_test(16'h5A5A, 0, 1'b1);
    repeat (10) @(negedge clk);
    chk("single_done", 32'(done_cnt), 32'd1);

    // abort a test in its fifth write cycle
    @(negedge clk);
    fault_mode = 0;
    seed       = 16'h3C3C;
    start      = 1'b1;
    push_expect(16'h3C3C, 0, 1'b0);
    start_ecnt = ecnt + 1;
    busy_chk   = 0;
    done_cnt   = 0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_en_write", 32'(en_write), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(addr), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    wq.delete();
    repeat (80) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);

    run_test(16'h0F0F, 0, 1'b0);
    repeat (3) @(negedge clk);

    chk("rw_exclusive", 32'(excl_err), 32'd0);
    chk("dmin_idle_zero", 32'(dmin_err), 32'd0);
    chk("addr_idle_zero", 32'(addr_err), 32'd0);
    chk("busy_window", 32'(busy_err), 32'd0);
    chk("write_queue_left", 32'(wq.size()), 32'd0);
    chk("result_queue_left", 32'(rq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
